// File: rtl/sha256_pkg.sv
// sha256_pkg
// Shared SHA-256 definitions for the compression core:
//   - FSM state encodings (ST_IDLE, ST_ROUND, ST_FINAL, ST_DONE)
//   - H_INIT: standard initial chaining hash, H0 in the top word
//   - K[0:63]: round constants
//   - rotr, big_sigma0, big_sigma1, ch, maj: 32-bit round helper functions
package sha256_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_FINAL = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [255:0] H_INIT =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_compress_core_if.sv
// sha256_compress_core_if
// Bundles the control/data signals between the schedule stage, the
// compression core and its consumer.
//   enable, w_complete, w_vector, hash_vector : into the core
//   busy, round_index, hash_complete, hash_out : out of the core
// master: the environment driving a block in; slave: the core itself.
interface sha256_compress_core_if #(
  parameter int W_LENGTH = 64
) ();

  logic                          enable;
  logic                          w_complete;
  logic [32*W_LENGTH-1:0]        w_vector;
  logic [255:0]                  hash_vector;
  logic                          busy;
  logic [$clog2(W_LENGTH):0]     round_index;
  logic                          hash_complete;
  logic [255:0]                  hash_out;

  modport master (
    output enable, w_complete, w_vector, hash_vector,
    input  busy, round_index, hash_complete, hash_out
  );

  modport slave (
    input  enable, w_complete, w_vector, hash_vector,
    output busy, round_index, hash_complete, hash_out
  );

endinterface

// File: rtl/sha256_round.sv
// sha256_round
// One combinational SHA-256 compression round.
//   cur : working variables a..h (element 0 = a, element 7 = h)
//   k_t : round constant K[t]
//   w_t : schedule word W[t]
//   nxt : working variables after the round
module sha256_round
  import sha256_pkg::*;
(
  input  logic [0:7][31:0] cur,
  input  logic [31:0]      k_t,
  input  logic [31:0]      w_t,
  output logic [0:7][31:0] nxt
);

  logic [31:0] t1;
  logic [31:0] t2;

  always_comb begin
    t1  = cur[7] + big_sigma1(cur[4]) + ch(cur[4], cur[5], cur[6]) + k_t + w_t;
    t2  = big_sigma0(cur[0]) + maj(cur[0], cur[1], cur[2]);
    nxt = {t1 + t2, cur[0], cur[1], cur[2], cur[3] + t1, cur[4], cur[5], cur[6]};
  end

endmodule

// File: rtl/sha256_compress_core.sv
// sha256_compress_core
// Runs the 64 SHA-256 compression rounds over a finished message schedule,
// one round per clock, and produces the updated chaining hash.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset, clears all state and outputs
//   bus   : slave side of sha256_compress_core_if
//           (enable, w_complete, w_vector, hash_vector in;
//            busy, round_index, hash_complete, hash_out out)
// Sequence: IDLE -capture-> ROUND x64 -> FINAL -> DONE -(w_complete low)-> IDLE
module sha256_compress_core
  import sha256_pkg::*;
#(
  parameter int W_LENGTH = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  sha256_compress_core_if.slave bus
);

  localparam int IDX_W   = $clog2(W_LENGTH);
  localparam int ROUND_W = IDX_W + 1;
  localparam logic [ROUND_W-1:0] LAST_T = ROUND_W'(W_LENGTH - 1);

  logic [1:0]              state;
  logic [ROUND_W-1:0]      t;
  logic [IDX_W-1:0]        t_idx;
  logic [0:7][31:0]        work;
  logic [0:7][31:0]        work_nxt;
  logic [32*W_LENGTH-1:0]  w_reg;
  logic [0:7][31:0]        h_reg;
  logic [0:7][31:0]        hash_out_r;
  logic                    hash_complete_r;
  logic [31:0]             w_t;

  // W[t] is picked straight out of the latched vector; the vector never shifts.
  assign t_idx = t[IDX_W-1:0];
  assign w_t   = w_reg[{t_idx, 5'b0} +: 32];

  sha256_round u_round (
    .cur (work),
    .k_t (K[t_idx]),
    .w_t (w_t),
    .nxt (work_nxt)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      t               <= '0;
      work            <= '0;
      w_reg           <= '0;
      h_reg           <= '0;
      hash_out_r      <= '0;
      hash_complete_r <= 1'b0;
    end else if (!bus.enable) begin
      state           <= ST_IDLE;
      t               <= '0;
      hash_out_r      <= '0;
      hash_complete_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Capture edge: later changes on the input vectors are ignored.
          if (bus.w_complete) begin
            w_reg <= bus.w_vector;
            h_reg <= bus.hash_vector;
            work  <= bus.hash_vector;
            t     <= '0;
            state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          work <= work_nxt;
          if (t == LAST_T) begin
            t     <= '0;
            state <= ST_FINAL;
          end else begin
            t <= t + 1'b1;
          end
        end
        ST_FINAL: begin
          for (int i = 0; i < 8; i++) begin
            hash_out_r[i] <= h_reg[i] + work[i];
          end
          hash_complete_r <= 1'b1;
          state           <= ST_DONE;
        end
        default: begin
          // Re-arm only on a low w_complete so a held level cannot retrigger.
          if (!bus.w_complete) begin
            hash_complete_r <= 1'b0;
            state           <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy          = (state == ST_ROUND) || (state == ST_FINAL);
  assign bus.round_index   = (state == ST_ROUND) ? t : '0;
  assign bus.hash_complete = hash_complete_r;
  assign bus.hash_out      = hash_out_r;

endmodule

// File: tb/tb_sha256_compress_core.sv
// tb_sha256_compress_core
// Scoreboard bench: every block driven pushes the reference digest for the
// captured inputs; the digest is popped and compared when hash_complete rises.
module tb_sha256_compress_core;

  typedef logic [0:15][31:0] blk_t;

  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_DIGEST =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  sha256_compress_core_if bus ();

  sha256_compress_core dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [255:0] exp_q [$];

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [2047:0] expand(input blk_t m);
    logic [31:0]   w [0:63];
    logic [2047:0] v;
    for (int i = 0; i < 16; i++) w[i] = m[i];
    for (int i = 16; i < 64; i++)
      w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7] +
             (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 64; i++) v[32*i +: 32] = w[i];
    return v;
  endfunction

  function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [2047:0] wv);
    logic [31:0] hw [0:7];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 8; i++) hw[i] = hin[255-32*i -: 32];
    a = hw[0]; b = hw[1]; c = hw[2]; d = hw[3];
    e = hw[4]; f = hw[5]; g = hw[6]; h = hw[7];
    for (int t = 0; t < 64; t++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) +
           sha256_pkg::K[t] + wv[32*t +: 32];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hw[0] + a, hw[1] + b, hw[2] + c, hw[3] + d,
            hw[4] + e, hw[5] + f, hw[6] + g, hw[7] + h};
  endfunction

  task automatic start_block(input logic [2047:0] wv, input logic [255:0] hv);
    bus.w_vector    = wv;
    bus.hash_vector = hv;
    bus.w_complete  = 1'b1;
    exp_q.push_back(ref_compress(hv, wv));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rearm();
    bus.w_complete = 1'b0;
    tick();
  endtask

  // Waits for hash_complete (bounded), then pops and compares the digest.
  task automatic wait_digest(input int k0, input bit scramble, output int lat);
    lat = -1;
    for (int k = k0; k < k0 + 200; k++) begin
      tick();
      if (scramble) begin
        for (int i = 0; i < 64; i++) bus.w_vector[32*i +: 32] = $urandom();
        for (int i = 0; i < 8; i++) bus.hash_vector[32*i +: 32] = $urandom();
      end
      if (bus.hash_complete) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      check_val("digest_timeout", 256'(bus.hash_complete), 256'd1);
    end else begin
      check_val("sb_depth", 256'(exp_q.size()), 256'd1);
      if (exp_q.size() > 0) check_val("digest", bus.hash_out, exp_q.pop_front());
    end
  endtask

  task automatic wait_round(input int target);
    for (int k = 0; k < 100; k++) begin
      tick();
      if (int'(bus.round_index) == target) break;
    end
    check_val("reach_round", 256'(bus.round_index), 256'(target));
  endtask

  initial begin
    blk_t          m;
    logic [2047:0] abc_w;
    logic [2047:0] empty_w;
    logic [255:0]  hr;
    int            lat;
    int            held;

    m = '0; m[0] = 32'h61626380; m[15] = 32'h00000018;
    abc_w = expand(m);
    m = '0; m[0] = 32'h80000000;
    empty_w = expand(m);

    reset           = 1'b1;
    bus.enable      = 1'b0;
    bus.w_complete  = 1'b0;
    bus.w_vector    = '0;
    bus.hash_vector = '0;
    #12;
    check_val("rst_busy", 256'(bus.busy), 256'd0);
    check_val("rst_round_index", 256'(bus.round_index), 256'd0);
    check_val("rst_hash_complete", 256'(bus.hash_complete), 256'd0);
    check_val("rst_hash_out", bus.hash_out, 256'd0);
    tick();
    reset      = 1'b0;
    bus.enable = 1'b1;
    tick();

    // "abc" block with round-0 working variables and latency
    start_block(abc_w, sha256_pkg::H_INIT);
    tick();
    check_val("abc_busy_e0", 256'(bus.busy), 256'd1);
    check_val("abc_ri_e0", 256'(bus.round_index), 256'd0);
    tick();
    check_val("abc_a_r0", 256'(dut.work[0]), 256'h5d6aebcd);
    check_val("abc_e_r0", 256'(dut.work[4]), 256'hfa2a4622);
    check_val("abc_ri_e1", 256'(bus.round_index), 256'd1);
    wait_digest(2, 1'b0, lat);
    check_val("abc_latency", 256'(lat), 256'd65);
    check_val("abc_const", bus.hash_out, ABC_DIGEST);

    // Held w_complete in DONE: no second run
    held = 0;
    repeat (20) begin
      tick();
      if (bus.hash_complete && !bus.busy && bus.round_index == '0) held++;
    end
    check_val("held_done_cycles", 256'(held), 256'd20);
    rearm();
    check_val("rearm_hash_complete", 256'(bus.hash_complete), 256'd0);
    check_val("rearm_hash_out_kept", bus.hash_out, ABC_DIGEST);

    // Empty message
    start_block(empty_w, sha256_pkg::H_INIT);
    wait_digest(0, 1'b0, lat);
    check_val("empty_latency", 256'(lat), 256'd65);
    check_val("empty_const", bus.hash_out, EMPTY_DIGEST);
    rearm();

    // Asynchronous reset at round 30
    start_block(abc_w, sha256_pkg::H_INIT);
    wait_round(30);
    #2 reset = 1'b1;
    #1;
    check_val("arst_busy", 256'(bus.busy), 256'd0);
    check_val("arst_round_index", 256'(bus.round_index), 256'd0);
    check_val("arst_hash_complete", 256'(bus.hash_complete), 256'd0);
    check_val("arst_hash_out", bus.hash_out, 256'd0);
    exp_q.delete();
    bus.w_complete = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    start_block(abc_w, sha256_pkg::H_INIT);
    wait_digest(0, 1'b0, lat);
    check_val("abc_rerun_latency", 256'(lat), 256'd65);
    check_val("abc_rerun_const", bus.hash_out, ABC_DIGEST);
    rearm();

    // enable low at round 10
    start_block(empty_w, sha256_pkg::H_INIT);
    wait_round(10);
    bus.enable = 1'b0;
    tick();
    check_val("en_busy", 256'(bus.busy), 256'd0);
    check_val("en_round_index", 256'(bus.round_index), 256'd0);
    check_val("en_hash_complete", 256'(bus.hash_complete), 256'd0);
    check_val("en_hash_out", bus.hash_out, 256'd0);
    exp_q.delete();
    bus.enable = 1'b1;
    start_block(empty_w, sha256_pkg::H_INIT);
    wait_digest(0, 1'b0, lat);
    check_val("en_rerun_latency", 256'(lat), 256'd65);
    check_val("en_rerun_const", bus.hash_out, EMPTY_DIGEST);
    rearm();

    // Inputs scrambled every cycle after the capture edge
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++) m[i] = $urandom();
      for (int i = 0; i < 8; i++) hr[32*i +: 32] = $urandom();
      start_block(expand(m), hr);
      wait_digest(0, 1'b1, lat);
      check_val("scramble_latency", 256'(lat), 256'd65);
      rearm();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sha256_compress_core.md
# sha256_compress_core

Consumes the finished 64-word message schedule and the incoming 256-bit chaining hash, runs the 64 SHA-256 compression rounds one per clock, and emits the updated chaining hash. Sits directly downstream of the W-schedule stage. It starts when that stage raises `w_complete`. Its output feeds the next block's `hash_vector`, or is the final digest.

## Interface
- `W_LENGTH`, default 64: rounds per block; fixed at 64 for SHA-256.
- `clock` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high; clears all state and outputs immediately.
- `enable` input, 1 bit: low forces a synchronous return to IDLE with outputs cleared.
- `w_complete` input, 1 bit: schedule-ready level from the upstream stage.
- `w_vector` input, 2048 bits: W[t] at bits [32t+31:32t], t = 0..63.
- `hash_vector` input, 256 bits: H0 at [255:224] through H7 at [31:0].
- `busy` output, 1 bit: high in ROUND and FINAL.
- `round_index` output, $clog2(W_LENGTH)+1 bits: current round t; 0 outside ROUND.
- `hash_complete` output, 1 bit: digest valid; held until re-arm.
- `hash_out` output, 256 bits: updated hash, same word packing as `hash_vector`.

## Operation
- **States:** IDLE, ROUND, FINAL, DONE.
- **IDLE:**
  - On an edge where `enable && w_complete`: latch `w_vector` into `w_reg` and `hash_vector` into `h_reg`.
  - Load a..h from `hash_vector`, set t=0, go to ROUND.
- **ROUND, one round per edge:**
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t].
  - T2 = Σ0(a) + Maj(a,b,c).
  - h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2.
  - t increments. After the round with t=63, go to FINAL.
- **Functions:**
  - Σ0 = ROTR2^ROTR13^ROTR22; Σ1 = ROTR6^ROTR11^ROTR25.
  - Ch = (e&f)^(~e&g); Maj = (a&b)^(a&c)^(b&c).
- **Arithmetic:** all additions are mod 2^32; carries are discarded, no saturation.
- **FINAL:** `hash_out` word i ← `h_reg` word i + working var i (mod 2^32). Set `hash_complete`=1 and go to DONE.
- **DONE:**
  - Hold `hash_out` and `hash_complete`.
  - Return to IDLE when `w_complete` is low; this is the re-arm. It prevents retriggering on a level that stays high.
  - Clear `hash_complete` on leaving DONE. `hash_out` keeps its value until the next FINAL.
- **Input stability:** changes on `w_vector`/`hash_vector` after the capture edge are ignored, because the latched copies are used.
- **`enable` low in any state:** go to IDLE; `hash_complete`=0, `hash_out`=0, t=0.
- **Reset values:** state IDLE, `busy`=0, `round_index`=0, `hash_complete`=0, `hash_out`=0, working vars 0.
- **Reset mid-round:** the block is aborted; there is no partial output.

## Timing
- **Capture edge = edge 0:** IDLE→ROUND.
- **Edges 1..64:** rounds t=0..63.
- **Edge 65:** FINAL result is registered and `hash_complete` rises, visible 65 cycles after capture.
- **Edge 66:** state DONE is held.
- **Throughput:** one block per 66 cycles minimum, plus the re-arm cycle with `w_complete` low.
- **`w_complete` while busy:** ignored.
- **`enable` and `w_complete` both high in DONE:** stay in DONE.

## Structure
- **Package `sha256_pkg`:**
  - `K[0:63]` constant array.
  - Initial `H_INIT` (6a09e667 … 5be0cd19).
  - State enum.
  - Functions `rotr`, `big_sigma0`, `big_sigma1`, `ch`, `maj`.
- **Sub-module `sha256_round`:** purely combinational; takes a..h, K[t] and W[t], returns next a..h. Keeps the FSM file small and lets the round be unit-tested.
- **W[t] select:** word mux from `w_reg` indexed by t; no shifting of the vector.

## Test plan
- **"abc" block:** `hash_vector`=`H_INIT`, W0=61626380, W1..W14=0, W15=00000018, W16..63 precomputed.
  - After round 0: a=5d6aebcd, e=fa2a4622.
  - `hash_out`=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, with `hash_complete` at cycle 65.
- **Empty message:** W0=80000000, all other words 0.
  - `hash_out`=e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- **Held `w_complete`:** keep it high through DONE for 20 cycles.
  - No second run; `hash_complete` stays 1.
  - Drop it: IDLE the next cycle, `hash_complete`=0.
- **Async reset mid-round:** assert `reset` at t=30.
  - All outputs 0 immediately, with no clock edge needed.
  - Rerun "abc": correct digest.
- **`enable` low at t=10:** IDLE at the next edge; `busy`=0, `round_index`=0.
  - Re-enable: a full 65-cycle run completes.
- **Input change after capture:** randomize `w_vector`/`hash_vector` on every cycle after edge 0.
  - Digest equals the reference-model result for the values captured at edge 0.
